// File: rtl/sample_window.sv
// Multi-channel circular capture window with decimation, freeze (hold) and
// synchronous clear. All outputs are registered; samples pass bit-exact.
module sample_window #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 64,
  parameter int CHANNELS = 2,
  parameter int DECIM    = 1
) (
  input  logic                                        clk_in,
  input  logic                                        rst_in,
  input  logic                                        ready_in,
  input  logic signed [CHANNELS-1:0][WIDTH-1:0]       signal_in,
  input  logic                                        freeze_in,
  input  logic                                        clear_in,
  output logic signed [CHANNELS-1:0][DEPTH-1:0][WIDTH-1:0] sample_out,
  output logic [$clog2(DEPTH)-1:0]                    offset,
  output logic                                        valid_out,
  output logic                                        full_out,
  output logic                                        frozen_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_r;
  logic [DW-1:0] decim_cnt_r;
  logic [AW:0]   fill_cnt_r;

  // Window storage, pointer, counters and state machine in one register block.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= FILL;
      sample_out  <= '0;
      offset      <= '0;
      decim_cnt_r <= '0;
      fill_cnt_r  <= '0;
      valid_out   <= 1'b0;
      full_out    <= 1'b0;
      frozen_out  <= 1'b0;
    end else if (clear_in) begin
      // Clear wins over strobe and freeze; freeze only steers the next state.
      sample_out  <= '0;
      offset      <= '0;
      decim_cnt_r <= '0;
      fill_cnt_r  <= '0;
      valid_out   <= 1'b0;
      full_out    <= 1'b0;
      frozen_out  <= freeze_in;
      state_r     <= freeze_in ? HOLD : FILL;
    end else begin
      valid_out <= 1'b0;
      case (state_r)
        FILL, RUN: begin
          if (freeze_in) begin
            state_r    <= HOLD;
            frozen_out <= 1'b1;
          end else if (ready_in) begin
            if (decim_cnt_r == DW'(DECIM - 1)) begin
              decim_cnt_r <= '0;
              for (int c = 0; c < CHANNELS; c++) begin
                sample_out[c][offset] <= signal_in[c];
              end
              offset    <= offset + AW'(1);
              valid_out <= 1'b1;
              if (state_r == FILL) begin
                fill_cnt_r <= fill_cnt_r + (AW+1)'(1);
                if (fill_cnt_r == (AW+1)'(DEPTH - 1)) begin
                  state_r  <= RUN;
                  full_out <= 1'b1;
                end else begin
                  state_r <= FILL;
                end
              end else begin
                state_r <= RUN;
              end
            end else begin
              decim_cnt_r <= decim_cnt_r + DW'(1);
            end
          end else begin
            state_r <= state_r;
          end
        end
        HOLD: begin
          // A strobe on the exit cycle is dropped; acceptance resumes next cycle.
          if (!freeze_in) begin
            state_r    <= full_out ? RUN : FILL;
            frozen_out <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r    <= FILL;
          frozen_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
